ibex_register_file_mp: RTL and testbench
========================================

IBEX_REGISTER_FILE_MP -- requirements
Module: ibex_register_file_mp

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, meaning register word width in bits.
REQ-002 The block SHALL have parameter RV32E, default 0, meaning 16 words (4-bit index) when 1 and 32 words when 0.
REQ-003 The block SHALL have parameter NumRead, default 2, range 1..4, meaning number of read ports.
REQ-004 The block SHALL have parameter NumWrite, default 2, range 1..2, meaning number of write ports.
REQ-005 The block SHALL have parameter WordZeroVal, default all-zero, meaning reset, clear and R0 value.
REQ-006 The block SHALL have clk_i, input, 1 bit, clock, rising edge.
REQ-007 The block SHALL have rst_ni, input, 1 bit, reset, asynchronous, active-low.
REQ-008 The block SHALL have raddr_i, input, NumRead*5 bits, read addresses, port p at bits [5p+4:5p].
REQ-009 The block SHALL have rdata_o, output, NumRead*DataWidth bits, read data, port p at slice p.
REQ-010 The block SHALL have waddr_i, input, NumWrite*5 bits, write addresses, packed like raddr_i.
REQ-011 The block SHALL have wdata_i, input, NumWrite*DataWidth bits, write data, packed like rdata_o.
REQ-012 The block SHALL have we_i, input, NumWrite bits, write enable per write port.
REQ-013 The block SHALL have clear_req_i, input, 1 bit, single-cycle request to clear every register.
REQ-014 The block SHALL have busy_o, output, 1 bit, high while the clear sequence runs.
REQ-015 The block SHALL have wr_drop_o, output, 1 bit, registered pulse reporting a write discarded during the clear sequence.
REQ-016 The block SHALL have conflict_o, output, 1 bit, registered pulse reporting two write ports enabled to the same nonzero address.

Function
REQ-017 Every read port SHALL return the addressed register combinationally; R0 SHALL always read WordZeroVal.
REQ-018 When RV32E=1, only address bits [3:0] SHALL be decoded for reads and writes.
REQ-019 An enabled write to a nonzero address SHALL update that register on the next rising clock edge; writes to R0 SHALL be discarded.
REQ-020 When both write ports target the same nonzero address in one cycle, port 1 data SHALL win, and conflict_o SHALL be high for exactly the following cycle.
REQ-021 The clear FSM SHALL have states IDLE and CLEAR; clear_req_i in IDLE SHALL move it to CLEAR with the index counter set to 1.
REQ-022 In CLEAR, the FSM SHALL write WordZeroVal to the indexed register once per cycle, then increment the index.
REQ-023 After writing the last word (15 or 31), the FSM SHALL return to IDLE, so a clear lasts NUM_WORDS-1 cycles.
REQ-024 busy_o SHALL equal (state==CLEAR).
REQ-025 clear_req_i received while in CLEAR SHALL be ignored.
REQ-026 Port writes during CLEAR SHALL be discarded, and wr_drop_o SHALL be high for the following cycle when any we_i bit was set.
REQ-027 Reads during CLEAR SHALL return current contents: cleared words return WordZeroVal and uncleared words return their old values.

Reset
REQ-028 Asserting rst_ni low SHALL asynchronously set all registers to WordZeroVal, the FSM to IDLE, the index to 1, and busy_o, wr_drop_o and conflict_o to 0.
REQ-029 Reset asserted mid-clear SHALL abort the sequence; no clear SHALL resume after reset is released.

Configuration
REQ-030 With macro IBEX_RF_BYPASS_EN defined, a read of a nonzero address that an enabled write port targets in the same cycle SHALL return that write data, with port 1 taking priority.
REQ-031 With IBEX_RF_BYPASS_EN undefined, such a read SHALL return the pre-write value; bypass SHALL never be applied during CLEAR.

Verification
REQ-032 Scenario: write port 0 sets x5=0xDEADBEEF, then read port 1 reads x5 -> 0xDEADBEEF next cycle; reading x0 -> 0.
REQ-033 Scenario: we_i=2'b11, both ports address x7, data 0x1111 and 0x2222 -> x7=0x2222, and conflict_o is high for exactly 1 cycle.
REQ-034 Scenario: fill x1..x31 with nonzero values, then pulse clear_req_i -> busy_o high for 31 cycles, all reads then return 0; a write issued in cycle 3 of the clear -> wr_drop_o pulse, and the write is lost.
REQ-035 Scenario: rst_ni low at clear cycle 10 -> busy_o drops immediately; after release all registers are 0 and the FSM is IDLE.
REQ-036 Scenario: write x9=0xA5A5A5A5 while reading x9 in the same cycle -> reads 0xA5A5A5A5 with IBEX_RF_BYPASS_EN, and the old value without it.
REQ-037 Scenario: RV32E=1, write to address 5'd17 -> x1 is updated; clear takes 15 cycles.

Source files
------------

// File: rtl/ibex_register_file_mp.sv
// Multi-port register file with a sequenced, one-word-per-cycle clear.
// Defining IBEX_RF_BYPASS_EN forwards same-cycle write data to matching read ports.
module ibex_register_file_mp #(
    parameter int unsigned          DataWidth   = 32,
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          NumRead     = 2,
    parameter int unsigned          NumWrite    = 2,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumRead*5-1:0]          raddr_i,
    output logic [NumRead*DataWidth-1:0]  rdata_o,
    input  logic [NumWrite*5-1:0]         waddr_i,
    input  logic [NumWrite*DataWidth-1:0] wdata_i,
    input  logic [NumWrite-1:0]           we_i,
    input  logic                          clear_req_i,
    output logic                          busy_o,
    output logic                          wr_drop_o,
    output logic                          conflict_o
);

    // state | meaning
    // IDLE  | normal operation, port writes accepted
    // CLEAR | writing WordZeroVal to word clr_idx each cycle, port writes dropped

    localparam int unsigned NumWords = RV32E ? 16 : 32;
    localparam int unsigned AW       = RV32E ? 4 : 5;
    localparam logic [AW-1:0] LastIdx = AW'(NumWords - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e              state;
    logic [AW-1:0]       clr_idx;
    logic [DataWidth-1:0] mem [NumWords];

    logic [AW-1:0]        waddr_dec [NumWrite];
    logic [AW-1:0]        raddr_dec [NumRead];
    logic [DataWidth-1:0] rd_word   [NumRead];
    logic                 conflict_d;

    always_comb begin
        for (int w = 0; w < NumWrite; w++) begin
            waddr_dec[w] = waddr_i[w*5 +: AW];
        end
    end

    generate
        if (NumWrite > 1) begin : g_conflict
            assign conflict_d = we_i[0] & we_i[1] &
                                (waddr_dec[0] == waddr_dec[1]) &
                                (waddr_dec[0] != '0);
        end else begin : g_no_conflict
            assign conflict_d = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            clr_idx    <= AW'(1);
            busy_o     <= 1'b0;
            wr_drop_o  <= 1'b0;
            conflict_o <= 1'b0;
        end else begin
            wr_drop_o  <= 1'b0;
            conflict_o <= 1'b0;
            case (state)
                IDLE: begin
                    conflict_o <= conflict_d;
                    if (clear_req_i) begin
                        state   <= CLEAR;
                        clr_idx <= AW'(1);
                        busy_o  <= 1'b1;
                    end
                end
                CLEAR: begin
                    wr_drop_o <= |we_i;
                    if (clr_idx == LastIdx) begin
                        state   <= IDLE;
                        clr_idx <= AW'(1);
                        busy_o  <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + AW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    clr_idx <= AW'(1);
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // Later write ports overwrite earlier ones, so port 1 wins on a collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumWords; i++) begin
                mem[i] <= WordZeroVal;
            end
        end else if (state == CLEAR) begin
            mem[clr_idx] <= WordZeroVal;
        end else begin
            for (int w = 0; w < NumWrite; w++) begin
                if (we_i[w] && (waddr_dec[w] != '0)) begin
                    mem[waddr_dec[w]] <= wdata_i[w*DataWidth +: DataWidth];
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NumRead; p++) begin
            raddr_dec[p] = raddr_i[p*5 +: AW];
            rd_word[p]   = (raddr_dec[p] == '0) ? WordZeroVal : mem[raddr_dec[p]];
`ifdef IBEX_RF_BYPASS_EN
            if ((state == IDLE) && (raddr_dec[p] != '0)) begin
                for (int w = 0; w < NumWrite; w++) begin
                    if (we_i[w] && (waddr_dec[w] == raddr_dec[p])) begin
                        rd_word[p] = wdata_i[w*DataWidth +: DataWidth];
                    end
                end
            end
`endif
        end
    end

    generate
        for (genvar p = 0; p < NumRead; p++) begin : g_rdata
            assign rdata_o[p*DataWidth +: DataWidth] = rd_word[p];
        end
    endgenerate

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Directed scoreboard bench for ibex_register_file_mp (RV32I and RV32E instances).
module tb_ibex_register_file_mp;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [9:0]  raddr, waddr;
    logic [63:0] wdata;
    logic [1:0]  we;
    logic        clr;
    logic [63:0] rdata;
    logic        busy, drop, conf;

    logic [9:0]  e_raddr, e_waddr;
    logic [63:0] e_wdata;
    logic [1:0]  e_we;
    logic        e_clr;
    logic [63:0] e_rdata;
    logic        e_busy, e_drop, e_conf;

    int tests = 0;
    int fails = 0;
    int cnt;
    logic [31:0] exp_q [$];
    logic [31:0] model [32];

    always #5 clk_i = ~clk_i;

    ibex_register_file_mp u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .raddr_i(raddr), .rdata_o(rdata),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .clear_req_i(clr),
        .busy_o(busy), .wr_drop_o(drop), .conflict_o(conf)
    );

    ibex_register_file_mp #(.RV32E(1'b1)) u_dut_e (
        .clk_i(clk_i), .rst_ni(rst_ni), .raddr_i(e_raddr), .rdata_o(e_rdata),
        .waddr_i(e_waddr), .wdata_i(e_wdata), .we_i(e_we), .clear_req_i(e_clr),
        .busy_o(e_busy), .wr_drop_o(e_drop), .conflict_o(e_conf)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_val(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic set_wr(input int port, input int addr, input logic [31:0] d);
        we[port] = 1'b1;
        waddr[port*5 +: 5] = 5'(addr);
        wdata[port*32 +: 32] = d;
    endtask

    task automatic set_rd(input int port, input int addr);
        raddr[port*5 +: 5] = 5'(addr);
    endtask

    initial begin
        raddr = '0; waddr = '0; wdata = '0; we = '0; clr = 1'b0;
        e_raddr = '0; e_waddr = '0; e_wdata = '0; e_we = '0; e_clr = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset state
        #12;
        set_rd(0, 5);
        #1;
        expect_val(32'h0); chk("reset_busy", {31'b0, busy});
        expect_val(32'h0); chk("reset_drop", {31'b0, drop});
        expect_val(32'h0); chk("reset_conflict", {31'b0, conf});
        expect_val(32'h0); chk("reset_read_x5", rdata[31:0]);
        rst_ni = 1'b1;
        tick();

        // Basic write on port 0, read back on port 1; x0 reads zero
        set_wr(0, 5, 32'hDEADBEEF); model[5] = 32'hDEADBEEF;
        tick();
        we = '0;
        set_rd(1, 5); set_rd(0, 0);
        #1;
        expect_val(model[5]); chk("read_x5_port1", rdata[63:32]);
        expect_val(32'h0);    chk("read_x0", rdata[31:0]);

        // Write to x0 is discarded
        set_wr(0, 0, 32'hFFFFFFFF);
        tick();
        we = '0;
        #1;
        expect_val(32'h0); chk("x0_after_write", rdata[31:0]);

        // Same-address dual write: port 1 wins, one-cycle conflict pulse
        set_wr(0, 7, 32'h1111); set_wr(1, 7, 32'h2222); model[7] = 32'h2222;
        tick();
        we = '0;
        set_rd(0, 7);
        #1;
        expect_val(32'h1); chk("conflict_pulse", {31'b0, conf});
        expect_val(model[7]); chk("conflict_winner", rdata[31:0]);
        tick();
        expect_val(32'h0); chk("conflict_cleared", {31'b0, conf});

        // Distinct dual write: both land, no conflict
        set_wr(0, 3, 32'h33); set_wr(1, 4, 32'h44); model[3] = 32'h33; model[4] = 32'h44;
        tick();
        we = '0;
        set_rd(0, 3); set_rd(1, 4);
        #1;
        expect_val(32'h0);    chk("no_conflict", {31'b0, conf});
        expect_val(model[3]); chk("dual_x3", rdata[31:0]);
        expect_val(model[4]); chk("dual_x4", rdata[63:32]);

        // Same-cycle read of a register being written
        set_wr(0, 9, 32'h12345678); model[9] = 32'h12345678;
        tick();
        set_rd(0, 9);
        set_wr(0, 9, 32'hA5A5A5A5);
        #1;
`ifdef IBEX_RF_BYPASS_EN
        expect_val(32'hA5A5A5A5);
`else
        expect_val(model[9]);
`endif
        chk("same_cycle_read_x9", rdata[31:0]);
        model[9] = 32'hA5A5A5A5;
        tick();
        we = '0;
        #1;
        expect_val(model[9]); chk("x9_after_write", rdata[31:0]);

        // Fill x1..x31
        for (int i = 1; i < 32; i++) begin
            model[i] = {8'(i), 24'hC0FFEE};
            set_wr(0, i, model[i]);
            tick();
        end
        we = '0;
        set_rd(0, 17); set_rd(1, 31);
        #1;
        expect_val(model[17]); chk("fill_x17", rdata[31:0]);
        expect_val(model[31]); chk("fill_x31", rdata[63:32]);

        // Full clear with a dropped write in cycle 3 and an ignored re-request in cycle 5
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 3) begin
                set_rd(0, 2); set_rd(1, 3);
                #1;
                expect_val(32'h0);    chk("mid_clear_x2", rdata[31:0]);
                expect_val(model[3]); chk("mid_clear_x3_old", rdata[63:32]);
                set_wr(0, 20, 32'hBAD0BAD0);
            end
            if (cnt == 5) clr = 1'b1;
            tick();
            we = '0; clr = 1'b0;
            if (cnt == 3) begin
                expect_val(32'h1); chk("wr_drop_pulse", {31'b0, drop});
            end
            if (cnt == 4) begin
                expect_val(32'h0); chk("wr_drop_cleared", {31'b0, drop});
            end
        end
        expect_val(32'd31); chk("clear_cycles", 32'(cnt));
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int i = 0; i < 32; i += 2) begin
            set_rd(0, i); set_rd(1, i + 1);
            #1;
            expect_val(model[i]);     chk($sformatf("cleared_x%0d", i), rdata[31:0]);
            expect_val(model[i + 1]); chk($sformatf("cleared_x%0d", i + 1), rdata[63:32]);
        end

        // Reset at clear cycle 10 aborts the sequence
        set_wr(0, 30, 32'h30303030); set_wr(1, 31, 32'h31313131);
        tick();
        we = '0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 9) begin
            cnt++;
            tick();
        end
        expect_val(32'h1); chk("busy_at_cycle10", {31'b0, busy});
        #2 rst_ni = 1'b0;
        #1;
        expect_val(32'h0); chk("busy_async_drop", {31'b0, busy});
        #3 rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        expect_val(32'h0); chk("no_resume_busy", {31'b0, busy});
        set_rd(0, 30); set_rd(1, 31);
        #1;
        expect_val(32'h0); chk("reset_x30", rdata[31:0]);
        expect_val(32'h0); chk("reset_x31", rdata[63:32]);

        // RV32E: address 17 aliases to x1, clear lasts 15 cycles
        e_we[0] = 1'b1; e_waddr[4:0] = 5'd17; e_wdata[31:0] = 32'h0000_0E17;
        tick();
        e_we = '0;
        e_raddr[4:0] = 5'd1; e_raddr[9:5] = 5'd17;
        #1;
        expect_val(32'h0000_0E17); chk("rv32e_x1", e_rdata[31:0]);
        expect_val(32'h0000_0E17); chk("rv32e_alias17", e_rdata[63:32]);
        e_clr = 1'b1;
        tick();
        e_clr = 1'b0;
        cnt = 0;
        while (e_busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        expect_val(32'd15); chk("rv32e_clear_cycles", 32'(cnt));
        expect_val(32'h0);  chk("rv32e_x1_cleared", e_rdata[31:0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
